// File: rtl/uart_param_core_if.sv
// Host-side bundle for uart_param_core: TX write handshake and RX result strobe.
// master = host/consumer, slave = UART core.
interface uart_param_core_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_valid;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 parity_error;
  logic                 stop_error;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, rx_data, rx_valid, parity_error, stop_error
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, rx_data, rx_valid, parity_error, stop_error
  );
endinterface

// File: rtl/uart_param_core.sv
// Parametrised full-duplex UART: oversample/baud tick generator, FIFO-fed TX,
// oversampled RX with parity/stop checking and internal loopback.
module uart_param_core #(
  parameter int CLK_FREQ      = 50_000_000,
  parameter int BAUD_RATE     = 9600,
  parameter int DATA_BITS     = 8,
  parameter int OVERSAMPLE    = 16,
  parameter int TX_FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  uart_param_core_if.slave                 bus,
  input  logic                             par_en,
  input  logic                             par_odd,
  input  logic                             two_stop,
  input  logic                             loopback,
  input  logic                             rxd_in,
  output logic                             txd_out,
  output logic                             tx_busy,
  output logic [$clog2(TX_FIFO_DEPTH):0]   tx_fifo_count
);

  localparam int OS_DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int OS_DIV     = (OS_DIV_RAW < 1) ? 1 : OS_DIV_RAW;
  localparam int DIV_W      = $clog2(OS_DIV + 1);
  localparam int OS_W       = $clog2(OVERSAMPLE);
  localparam int BIT_W      = $clog2(DATA_BITS);
  localparam int PTR_W      = $clog2(TX_FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(OS_DIV - 1);
  localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_HALF   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(TX_FIFO_DEPTH);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // ---------------- tick generation ----------------
  logic [DIV_W-1:0] div_cnt_reg;
  logic [OS_W-1:0]  os_cnt_reg;
  logic             os_tick;
  logic             bit_tick;

  assign os_tick  = (div_cnt_reg == DIV_LAST);
  assign bit_tick = os_tick && (os_cnt_reg == OS_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_reg <= '0;
      os_cnt_reg  <= '0;
    end else begin
      div_cnt_reg <= os_tick ? '0 : div_cnt_reg + 1'b1;
      if (os_tick)
        os_cnt_reg <= (os_cnt_reg == OS_LAST) ? '0 : os_cnt_reg + 1'b1;
    end
  end

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] fifo_mem [TX_FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg;
  logic [PTR_W-1:0]     rd_ptr_reg;
  logic [CNT_W-1:0]     count_reg;
  logic                 fifo_ready;
  logic                 push;
  logic                 pop;

  assign fifo_ready    = (count_reg != FIFO_FULL);
  assign push          = bus.tx_valid && fifo_ready;
  assign bus.tx_ready  = fifo_ready;
  assign tx_fifo_count = count_reg;

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr_reg] <= bus.tx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ---------------- TX FSM ----------------
  logic [2:0]           tx_state_reg;
  logic [DATA_BITS-1:0] tx_shift_reg;
  logic [BIT_W-1:0]     tx_bit_reg;
  logic                 tx_par_bit_reg;
  logic                 tx_par_en_reg;
  logic                 tx_two_stop_reg;
  logic                 tx_stop2_reg;
  logic                 txd_reg;
  logic                 tx_stop_done;

  assign tx_stop_done = !tx_two_stop_reg || tx_stop2_reg;
  // A new word is taken either from idle or straight off the last stop bit,
  // so queued frames follow each other with no idle gap.
  assign pop = bit_tick && (count_reg != '0) &&
               ((tx_state_reg == ST_IDLE) || ((tx_state_reg == ST_STOP) && tx_stop_done));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_reg    <= ST_IDLE;
      tx_shift_reg    <= '0;
      tx_bit_reg      <= '0;
      tx_par_bit_reg  <= 1'b0;
      tx_par_en_reg   <= 1'b0;
      tx_two_stop_reg <= 1'b0;
      tx_stop2_reg    <= 1'b0;
      txd_reg         <= 1'b1;
    end else if (bit_tick) begin
      if (pop) begin
        tx_shift_reg    <= fifo_mem[rd_ptr_reg];
        tx_par_bit_reg  <= ^fifo_mem[rd_ptr_reg] ^ par_odd;
        tx_par_en_reg   <= par_en;
        tx_two_stop_reg <= two_stop;
        tx_stop2_reg    <= 1'b0;
        tx_bit_reg      <= '0;
        txd_reg         <= 1'b0;
        tx_state_reg    <= ST_START;
      end else begin
        case (tx_state_reg)
          ST_IDLE: begin
            txd_reg <= 1'b1;
          end
          ST_START: begin
            txd_reg      <= tx_shift_reg[0];
            tx_shift_reg <= tx_shift_reg >> 1;
            tx_bit_reg   <= '0;
            tx_state_reg <= ST_DATA;
          end
          ST_DATA: begin
            if (tx_bit_reg == DATA_LAST) begin
              if (tx_par_en_reg) begin
                txd_reg      <= tx_par_bit_reg;
                tx_state_reg <= ST_PARITY;
              end else begin
                txd_reg      <= 1'b1;
                tx_stop2_reg <= 1'b0;
                tx_state_reg <= ST_STOP;
              end
            end else begin
              txd_reg      <= tx_shift_reg[0];
              tx_shift_reg <= tx_shift_reg >> 1;
              tx_bit_reg   <= tx_bit_reg + 1'b1;
            end
          end
          ST_PARITY: begin
            txd_reg      <= 1'b1;
            tx_stop2_reg <= 1'b0;
            tx_state_reg <= ST_STOP;
          end
          ST_STOP: begin
            if (!tx_stop_done)
              tx_stop2_reg <= 1'b1;
            else
              tx_state_reg <= ST_IDLE;
          end
          default: begin
            txd_reg      <= 1'b1;
            tx_state_reg <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign tx_busy = (count_reg != '0) || (tx_state_reg != ST_IDLE);
  assign txd_out = loopback ? 1'b1 : txd_reg;

  // ---------------- RX path ----------------
  logic rx_sync1_reg;
  logic rx_sync2_reg;
  logic rx_line;
  logic rx_prev_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync1_reg <= 1'b1;
      rx_sync2_reg <= 1'b1;
    end else begin
      rx_sync1_reg <= rxd_in;
      rx_sync2_reg <= rx_sync1_reg;
    end
  end

  // Internal TX serial is already in this clock domain, so it bypasses the synchroniser.
  assign rx_line = loopback ? txd_reg : rx_sync2_reg;

  logic [2:0]           rx_state_reg;
  logic [OS_W-1:0]      rx_cnt_reg;
  logic [BIT_W-1:0]     rx_bit_reg;
  logic [DATA_BITS-1:0] rx_shift_reg;
  logic                 rx_par_en_reg;
  logic                 rx_par_odd_reg;
  logic                 rx_par_bit_reg;
  logic [DATA_BITS-1:0] rx_data_reg;
  logic                 rx_valid_reg;
  logic                 parity_error_reg;
  logic                 stop_error_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_prev_reg      <= 1'b1;
      rx_state_reg     <= ST_IDLE;
      rx_cnt_reg       <= '0;
      rx_bit_reg       <= '0;
      rx_shift_reg     <= '0;
      rx_par_en_reg    <= 1'b0;
      rx_par_odd_reg   <= 1'b0;
      rx_par_bit_reg   <= 1'b0;
      rx_data_reg      <= '0;
      rx_valid_reg     <= 1'b0;
      parity_error_reg <= 1'b0;
      stop_error_reg   <= 1'b0;
    end else begin
      rx_valid_reg <= 1'b0;
      if (os_tick) begin
        rx_prev_reg <= rx_line;
        case (rx_state_reg)
          ST_IDLE: begin
            if (rx_prev_reg && !rx_line) begin
              rx_par_en_reg  <= par_en;
              rx_par_odd_reg <= par_odd;
              rx_cnt_reg     <= '0;
              rx_state_reg   <= ST_START;
            end
          end
          ST_START: begin
            if (rx_cnt_reg == OS_HALF) begin
              rx_cnt_reg   <= '0;
              rx_bit_reg   <= '0;
              rx_state_reg <= rx_line ? ST_IDLE : ST_DATA;
            end else begin
              rx_cnt_reg <= rx_cnt_reg + 1'b1;
            end
          end
          ST_DATA: begin
            if (rx_cnt_reg == OS_LAST) begin
              rx_cnt_reg   <= '0;
              rx_shift_reg <= {rx_line, rx_shift_reg[DATA_BITS-1:1]};
              if (rx_bit_reg == DATA_LAST)
                rx_state_reg <= rx_par_en_reg ? ST_PARITY : ST_STOP;
              else
                rx_bit_reg <= rx_bit_reg + 1'b1;
            end else begin
              rx_cnt_reg <= rx_cnt_reg + 1'b1;
            end
          end
          ST_PARITY: begin
            if (rx_cnt_reg == OS_LAST) begin
              rx_cnt_reg     <= '0;
              rx_par_bit_reg <= rx_line;
              rx_state_reg   <= ST_STOP;
            end else begin
              rx_cnt_reg <= rx_cnt_reg + 1'b1;
            end
          end
          ST_STOP: begin
            if (rx_cnt_reg == OS_LAST) begin
              rx_cnt_reg       <= '0;
              rx_data_reg      <= rx_shift_reg;
              rx_valid_reg     <= 1'b1;
              parity_error_reg <= rx_par_en_reg &&
                                  ((^rx_shift_reg ^ rx_par_odd_reg) != rx_par_bit_reg);
              stop_error_reg   <= !rx_line;
              rx_state_reg     <= ST_IDLE;
            end else begin
              rx_cnt_reg <= rx_cnt_reg + 1'b1;
            end
          end
          default: begin
            rx_cnt_reg   <= '0;
            rx_state_reg <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.rx_data      = rx_data_reg;
  assign bus.rx_valid     = rx_valid_reg;
  assign bus.parity_error = parity_error_reg;
  assign bus.stop_error   = stop_error_reg;

endmodule

// File: tb/tb_uart_param_core.sv
// Bench for uart_param_core: directed and randomized frames checked against a
// frame-level reference model (expected words, flags and frame spacing).
module tb_uart_param_core;

  localparam int CLK_FREQ  = 1_600_000;
  localparam int BAUD_RATE = 100_000;
  localparam int OS        = 16;
  localparam int DEPTH     = 4;
  localparam int BIT_CLKS  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 8-bit instance
  logic       par_en = 1'b0, par_odd = 1'b0, two_stop = 1'b0, loopback = 1'b0, rxd_in = 1'b1;
  logic       txd_out, tx_busy;
  logic [2:0] tx_fifo_count;
  uart_param_core_if #(.DATA_BITS(8)) bus ();

  uart_param_core #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .DATA_BITS(8),
    .OVERSAMPLE(OS), .TX_FIFO_DEPTH(DEPTH)
  ) u_dut (
    .clk(clk), .rst(rst), .bus(bus),
    .par_en(par_en), .par_odd(par_odd), .two_stop(two_stop), .loopback(loopback),
    .rxd_in(rxd_in), .txd_out(txd_out), .tx_busy(tx_busy), .tx_fifo_count(tx_fifo_count)
  );

  // 9-bit instance, two stop bits, loopback
  logic       par_en9 = 1'b0, par_odd9 = 1'b0, two_stop9 = 1'b1, loopback9 = 1'b1, rxd9 = 1'b1;
  logic       txd9, busy9;
  logic [2:0] count9;
  uart_param_core_if #(.DATA_BITS(9)) bus9 ();

  uart_param_core #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .DATA_BITS(9),
    .OVERSAMPLE(OS), .TX_FIFO_DEPTH(DEPTH)
  ) u_dut9 (
    .clk(clk), .rst(rst), .bus(bus9),
    .par_en(par_en9), .par_odd(par_odd9), .two_stop(two_stop9), .loopback(loopback9),
    .rxd_in(rxd9), .txd_out(txd9), .tx_busy(busy9), .tx_fifo_count(count9)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Monitors: cycle counter, received-frame logs, txd low-cycle counter
  longint     cyc = 0;
  logic [9:0] rx_q[$];
  longint     rx_t[$];
  logic [10:0] rx9_q[$];
  longint     rx9_t[$];
  int         txd_low = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && bus.rx_valid) begin
      rx_q.push_back({bus.stop_error, bus.parity_error, bus.rx_data});
      rx_t.push_back(cyc);
      $display("rx8 data=0x%02h perr=%0d serr=%0d cyc=%0d",
               bus.rx_data, bus.parity_error, bus.stop_error, cyc);
    end
    if (!rst && bus9.rx_valid) begin
      rx9_q.push_back({bus9.stop_error, bus9.parity_error, bus9.rx_data});
      rx9_t.push_back(cyc);
      $display("rx9 data=0x%03h perr=%0d serr=%0d cyc=%0d",
               bus9.rx_data, bus9.parity_error, bus9.stop_error, cyc);
    end
    if (!txd_out) txd_low <= txd_low + 1;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference model for one received frame: {stop_error, parity_error, word}
  function automatic logic [9:0] model_frame(input logic [7:0] w, input logic pe,
                                             input logic po, input logic pbit, input logic sbit);
    int   ones;
    logic perr;
    ones = $countones(w);
    perr = pe && (((ones + int'(pbit)) % 2) != int'(po));
    return {~sbit, perr, w};
  endfunction

  task automatic write_word(input logic [7:0] w, output int waited);
    waited = 0;
    while (!bus.tx_ready && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 1000) check_val("ready_timeout", {31'd0, bus.tx_ready}, 1);
    bus.tx_valid = 1'b1;
    bus.tx_data  = w;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic write_word9(input logic [8:0] w);
    int k;
    k = 0;
    while (!bus9.tx_ready && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 1000) check_val("ready9_timeout", {31'd0, bus9.tx_ready}, 1);
    bus9.tx_valid = 1'b1;
    bus9.tx_data  = w;
    @(negedge clk);
    bus9.tx_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k;
    k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    if (rx_q.size() < n) check_val("rx_timeout", rx_q.size(), n);
  endtask

  task automatic send_frame(input logic [7:0] w, input logic pe, input logic pbit, input logic sbit);
    rxd_in = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd_in = w[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    if (pe) begin
      rxd_in = pbit;
      repeat (BIT_CLKS) @(negedge clk);
    end
    rxd_in = sbit;
    repeat (BIT_CLKS) @(negedge clk);
    rxd_in = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
  endtask

  initial begin
    int          waited, k, base, base_low;
    logic [10:0] got_bits, exp_bits;
    logic [7:0]  w;
    logic        pe, po, pbit, sbit;
    logic [8:0]  words9 [3];

    bus.tx_valid  = 1'b0;
    bus.tx_data   = '0;
    bus9.tx_valid = 1'b0;
    bus9.tx_data  = '0;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check_val("rst_txd", {31'd0, txd_out}, 1);
    check_val("rst_ready", {31'd0, bus.tx_ready}, 1);
    check_val("rst_busy", {31'd0, tx_busy}, 0);
    check_val("rst_count", {29'd0, tx_fifo_count}, 0);
    check_val("rst_rx", {21'd0, bus.rx_valid, bus.parity_error, bus.stop_error, bus.rx_data}, 0);
    rst = 1'b0;
    @(negedge clk);

    // ---- TX serialization on the external pin, 8E1 ----
    par_en = 1'b1; par_odd = 1'b0;
    write_word(8'hA5, waited);
    k = 0;
    while (txd_out && k < 100) begin @(negedge clk); k++; end
    check_val("tx_start_seen", {31'd0, txd_out}, 0);
    repeat (BIT_CLKS / 2) @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      got_bits[i] = txd_out;
      repeat (BIT_CLKS) @(negedge clk);
    end
    exp_bits = {1'b1, 1'($countones(8'hA5) % 2), 8'hA5, 1'b0};
    check_val("tx_frame_a5", {21'd0, got_bits}, {21'd0, exp_bits});
    k = 0;
    while (tx_busy && k < 200) begin @(negedge clk); k++; end
    check_val("tx_done_busy", {31'd0, tx_busy}, 0);

    // ---- asynchronous reset mid-frame with a word still queued ----
    write_word(8'hA5, waited);
    write_word(8'h3C, waited);
    k = 0;
    while (txd_out && k < 100) begin @(negedge clk); k++; end
    repeat (40) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check_val("midrst_txd", {31'd0, txd_out}, 1);
    check_val("midrst_busy", {31'd0, tx_busy}, 0);
    check_val("midrst_count", {29'd0, tx_fifo_count}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    base_low = txd_low;
    repeat (300) @(negedge clk);
    check_val("midrst_no_resume", txd_low - base_low, 0);
    par_en = 1'b0;

    // ---- loopback 8N1 single word ----
    loopback = 1'b1; two_stop = 1'b0;
    base = rx_q.size();
    base_low = txd_low;
    write_word(8'h5A, waited);
    wait_rx(base + 1, 400);
    repeat (200) @(negedge clk);
    check_val("lb_count", rx_q.size() - base, 1);
    if (rx_q.size() > base) check_val("lb_5a", {22'd0, rx_q[base]}, {22'd0, model_frame(8'h5A, 0, 0, 0, 1)});

    // ---- FIFO fill, full-write ignored, back-to-back frames ----
    base = rx_q.size();
    write_word(8'h01, waited);
    k = 0;
    while (tx_fifo_count != 0 && k < 100) begin @(negedge clk); k++; end
    for (int i = 2; i <= 5; i++) write_word(8'(i), waited);
    check_val("fifo_count_full", {29'd0, tx_fifo_count}, 4);
    check_val("fifo_ready_full", {31'd0, bus.tx_ready}, 0);
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'h77;
    repeat (3) @(negedge clk);
    bus.tx_valid = 1'b0;
    check_val("fifo_full_ignore", {29'd0, tx_fifo_count}, 4);
    write_word(8'h06, waited);
    check_val("fifo_held_write", {31'd0, waited > 0}, 1);
    wait_rx(base + 6, 2000);
    repeat (400) @(negedge clk);
    check_val("fifo_rx_count", rx_q.size() - base, 6);
    for (int i = 0; i < 6; i++) begin
      if (rx_q.size() > base + i)
        check_val($sformatf("fifo_word%0d", i), {22'd0, rx_q[base + i]},
                  {22'd0, model_frame(8'(i + 1), 0, 0, 0, 1)});
      if (i > 0 && rx_t.size() > base + i)
        check_val($sformatf("fifo_gap%0d", i), 32'(rx_t[base + i] - rx_t[base + i - 1]), 10 * BIT_CLKS);
    end
    check_val("lb_txd_held", txd_low - base_low, 0);

    // ---- randomized loopback words and formats ----
    for (int n = 0; n < 6; n++) begin
      w        = 8'($urandom);
      par_en   = 1'($urandom);
      par_odd  = 1'($urandom);
      two_stop = 1'($urandom);
      base = rx_q.size();
      write_word(w, waited);
      wait_rx(base + 1, 400);
      if (rx_q.size() > base)
        check_val($sformatf("lb_rand%0d", n), {22'd0, rx_q[base]}, {22'd0, model_frame(w, 0, 0, 0, 1)});
    end
    repeat (60) @(negedge clk);
    loopback = 1'b0; two_stop = 1'b0;
    repeat (10) @(negedge clk);

    // ---- parity checking on external input, odd parity, 0x03 ----
    par_en = 1'b1; par_odd = 1'b1;
    base = rx_q.size();
    send_frame(8'h03, 1'b1, 1'b0, 1'b1);
    wait_rx(base + 1, 100);
    if (rx_q.size() > base) check_val("par_bad", {22'd0, rx_q[base]}, {22'd0, model_frame(8'h03, 1, 1, 0, 1)});
    send_frame(8'h03, 1'b1, 1'b1, 1'b1);
    wait_rx(base + 2, 100);
    if (rx_q.size() > base + 1) check_val("par_good", {22'd0, rx_q[base + 1]}, {22'd0, model_frame(8'h03, 1, 1, 1, 1)});

    // ---- framing error, flag hold, cleared by good frame ----
    par_en = 1'b0;
    base = rx_q.size();
    send_frame(8'h81, 1'b0, 1'b0, 1'b0);
    wait_rx(base + 1, 100);
    if (rx_q.size() > base) check_val("stop_bad", {22'd0, rx_q[base]}, {22'd0, model_frame(8'h81, 0, 0, 0, 0)});
    check_val("stop_flag_hold", {31'd0, bus.stop_error}, 1);
    send_frame(8'h42, 1'b0, 1'b0, 1'b1);
    wait_rx(base + 2, 100);
    if (rx_q.size() > base + 1) check_val("stop_clear", {22'd0, rx_q[base + 1]}, {22'd0, model_frame(8'h42, 0, 0, 0, 1)});

    // ---- randomized external frames with injected parity/stop faults ----
    for (int n = 0; n < 8; n++) begin
      w    = 8'($urandom);
      pe   = 1'($urandom);
      po   = 1'($urandom);
      pbit = 1'($urandom);
      sbit = ($urandom_range(3) != 0);
      par_en = pe; par_odd = po;
      base = rx_q.size();
      send_frame(w, pe, pbit, sbit);
      wait_rx(base + 1, 100);
      if (rx_q.size() > base)
        check_val($sformatf("ext_rand%0d", n), {22'd0, rx_q[base]}, {22'd0, model_frame(w, pe, po, pbit, sbit)});
    end
    par_en = 1'b0;

    // ---- glitch rejection ----
    base = rx_q.size();
    rxd_in = 1'b0;
    repeat (4) @(negedge clk);
    rxd_in = 1'b1;
    repeat (100) @(negedge clk);
    check_val("glitch_none", rx_q.size() - base, 0);

    // ---- 9-bit data, two stop bits, loopback: 12-bit frames back-to-back ----
    words9[0] = 9'h1FF;
    words9[1] = 9'h000;
    words9[2] = 9'($urandom);
    base = rx9_q.size();
    for (int i = 0; i < 3; i++) write_word9(words9[i]);
    k = 0;
    while (rx9_q.size() < base + 3 && k < 1500) begin @(negedge clk); k++; end
    @(negedge clk);
    check_val("w9_count", rx9_q.size() - base, 3);
    for (int i = 0; i < 3; i++) begin
      if (rx9_q.size() > base + i)
        check_val($sformatf("w9_word%0d", i), {21'd0, rx9_q[base + i]}, {21'd0, 2'b00, words9[i]});
      if (i > 0 && rx9_t.size() > base + i)
        check_val($sformatf("w9_gap%0d", i), 32'(rx9_t[base + i] - rx9_t[base + i - 1]), 12 * BIT_CLKS);
    end
    check_val("w9_txd_held", {31'd0, txd9}, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
